// File: rtl/bit_lock_ctrl.sv
// bit_lock_ctrl: acquisition/tracking/lock controller that turns per-edge
// interval measurements into a bit-period word and phase-realign strobe.
// Ports: clk_300M, rst_n (async, active-low), edge_strobe, interval[CLK_LEN],
//   restart -> period[CLK_LEN], period_valid, phase_sync, locked,
//   state[2] (IDLE=0 ACQUIRE=1 TRACK=2 LOCKED=3), loss_cnt[8].
// Optional: define BIT_LOCK_TIMEOUT_EN to add an edge-silence timeout
//   in TRACK/LOCKED (period << TIMEOUT_SHIFT cycles).
module bit_lock_ctrl #(
   parameter int CLK_LEN       = 32,
   parameter int STABLE_LEN    = 4,
   parameter int LOCK_EDGES    = 16,
   parameter int MISS_LIMIT    = 4,
   parameter int TOL_SHIFT     = 3,
   parameter int MIN_PERIOD    = 4,
   parameter int TIMEOUT_SHIFT = 5
) (
   input  logic               clk_300M,
   input  logic               rst_n,
   input  logic               edge_strobe,
   input  logic [CLK_LEN-1:0] interval,
   input  logic               restart,
   output logic [CLK_LEN-1:0] period,
   output logic               period_valid,
   output logic               phase_sync,
   output logic               locked,
   output logic [1:0]         state,
   output logic [7:0]         loss_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   localparam int HIT_W  = $clog2(LOCK_EDGES + 1);
   localparam int MISS_W = $clog2(MISS_LIMIT + 1);

   localparam logic [CLK_LEN-1:0] PER_ONES = '1;
   localparam logic [CLK_LEN-1:0] PER_MAX =
      {{(CLK_LEN-1){1'b1}}, 1'b0};
   localparam logic [CLK_LEN-1:0] PER_MIN =
      CLK_LEN'(MIN_PERIOD);
   localparam logic [HIT_W-1:0] HIT_LAST =
      HIT_W'(LOCK_EDGES - 1);
   localparam logic [MISS_W-1:0] MISS_LAST =
      MISS_W'(MISS_LIMIT - 1);

   state_t                st;
   logic [STABLE_LEN-1:0] stable;
   logic [HIT_W-1:0]      hit_cnt;
   logic [MISS_W-1:0]     miss_cnt;

   assign state = st;

   // Glitch filter: too-short intervals never reach the FSM.
   logic edge_ok;
   assign edge_ok = edge_strobe && (interval >= PER_MIN);

   logic trk;
   assign trk = (st == TRACK) || (st == LOCKED);

   // Classification window, one bit wider so period+tol and
   // 2*period-tol cannot wrap.
   logic [CLK_LEN:0] p_ext;
   logic [CLK_LEN:0] iv_ext;
   logic [CLK_LEN:0] tol;
   logic [CLK_LEN:0] lo;
   logic [CLK_LEN:0] hi;
   logic [CLK_LEN:0] dbl;
   logic [CLK_LEN:0] ign;

   assign p_ext  = {1'b0, period};
   assign iv_ext = {1'b0, interval};
   assign tol    = p_ext >> TOL_SHIFT;
   assign lo     = p_ext - tol;
   assign hi     = p_ext + tol;
   assign dbl    = {period, 1'b0};
   assign ign    = dbl - tol;

   logic is_hit;
   logic is_ign;
   logic is_miss;

   assign is_hit  = (iv_ext >= lo) && (iv_ext <= hi);
   assign is_ign  = !is_hit && (iv_ext >= ign);
   assign is_miss = !is_hit && !is_ign;

   // Slow tracking: one count toward the measured interval per hit,
   // clamped so the estimate stays usable and never saturates.
   logic [CLK_LEN-1:0] per_step;

   always_comb begin
      per_step = period;
      if ((interval > period) && (period < PER_MAX))
         per_step = period + 1'b1;
      else if ((interval < period) && (period > PER_MIN))
         per_step = period - 1'b1;
   end

   logic miss_loss;
   assign miss_loss = edge_ok && trk && is_miss &&
                      (miss_cnt == MISS_LAST);

   logic tmo_loss;

`ifdef BIT_LOCK_TIMEOUT_EN
   localparam int TMO_W = CLK_LEN + TIMEOUT_SHIFT;

   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_lim;

   assign tmo_lim = {period, {TIMEOUT_SHIFT{1'b0}}};

   // Cycles since the last strobe; only meaningful while tracking.
   always_ff @(posedge clk_300M or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (restart || !trk || edge_strobe)
         tmo_cnt <= '0;
      else if (tmo_cnt != '1)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_loss = trk && !edge_strobe &&
                     (tmo_cnt > tmo_lim);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_SHIFT != 0);
   assign tmo_loss = 1'b0;
`endif

   logic lose;
   assign lose = miss_loss || tmo_loss;

   always_ff @(posedge clk_300M or negedge rst_n) begin
      if (!rst_n) begin
         st           <= IDLE;
         period       <= PER_ONES;
         period_valid <= 1'b0;
         phase_sync   <= 1'b0;
         locked       <= 1'b0;
         loss_cnt     <= '0;
         stable       <= '0;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
      end else begin
         phase_sync <= 1'b0;
         if (restart || lose) begin
            // restart shares the loss teardown but is not a loss.
            st           <= IDLE;
            period       <= PER_ONES;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stable       <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            if (!restart && (loss_cnt != 8'hFF))
               loss_cnt <= loss_cnt + 8'd1;
         end else if (edge_ok) begin
            unique case (st)
               IDLE: begin
                  st <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (interval < period) begin
                     period <= interval;
                     stable <= '0;
                  end else if (&stable) begin
                     st           <= TRACK;
                     period_valid <= 1'b1;
                     hit_cnt      <= '0;
                     miss_cnt     <= '0;
                  end else begin
                     stable <= stable + 1'b1;
                  end
               end
               TRACK, LOCKED: begin
                  unique case (1'b1)
                     is_hit: begin
                        miss_cnt <= '0;
                        period   <= per_step;
                        if (st == LOCKED) begin
                           phase_sync <= 1'b1;
                        end else if (hit_cnt == HIT_LAST) begin
                           st         <= LOCKED;
                           locked     <= 1'b1;
                           phase_sync <= 1'b1;
                        end else begin
                           hit_cnt <= hit_cnt + 1'b1;
                        end
                     end
                     is_ign: begin
                        // Run of identical bits: no information.
                     end
                     is_miss: begin
                        miss_cnt <= miss_cnt + 1'b1;
                     end
                  endcase
               end
               default: begin
                  st <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_lock_ctrl.sv
// tb_bit_lock_ctrl: directed sequence for bit_lock_ctrl with a
// cycle-accurate reference model feeding an expectation queue.
module tb_bit_lock_ctrl;

   logic        clk_300M = 1'b0;
   logic        rst_n = 1'b0;
   logic        edge_strobe = 1'b0;
   logic [31:0] interval = '0;
   logic        restart = 1'b0;
   logic [31:0] period;
   logic        period_valid;
   logic        phase_sync;
   logic        locked;
   logic [1:0]  state;
   logic [7:0]  loss_cnt;

   bit_lock_ctrl dut (
      .clk_300M     (clk_300M),
      .rst_n        (rst_n),
      .edge_strobe  (edge_strobe),
      .interval     (interval),
      .restart      (restart),
      .period       (period),
      .period_valid (period_valid),
      .phase_sync   (phase_sync),
      .locked       (locked),
      .state        (state),
      .loss_cnt     (loss_cnt)
   );

   always #5 clk_300M = ~clk_300M;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] per;
      logic        pv;
      logic        lk;
      logic        ps;
      logic [7:0]  lc;
   } snap_t;

   snap_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   int     m_st;
   longint m_per;
   bit     m_pv;
   bit     m_lk;
   int     m_lc;
   int     m_stab;
   int     m_hits;
   int     m_miss;
   longint m_tc;

   localparam longint ONES = 64'hFFFF_FFFF;

   task automatic model_reset();
      m_st = 0; m_per = ONES; m_pv = 0; m_lk = 0;
      m_lc = 0; m_stab = 0; m_hits = 0; m_miss = 0;
      m_tc = 0;
   endtask

   task automatic model_step(input logic es,
                             input logic [31:0] ivl,
                             input logic rs);
      int     st0;
      longint per0;
      longint iv;
      longint tl;
      bit     trk0;
      bit     lose;
      bit     drop;
      bit     ps;
      snap_t  s;
      st0 = m_st;
      per0 = m_per;
      iv = longint'(ivl);
      trk0 = (st0 >= 2);
      lose = 0; drop = 0; ps = 0;
      if (rs) begin
         drop = 1;
      end else if (es) begin
         if (iv >= 4) begin
            if (m_st == 0) begin
               m_st = 1;
            end else if (m_st == 1) begin
               if (iv < m_per) begin
                  m_per = iv; m_stab = 0;
               end else if (m_stab == 15) begin
                  m_st = 2; m_pv = 1; m_hits = 0; m_miss = 0;
               end else begin
                  m_stab++;
               end
            end else begin
               tl = m_per / 8;
               if (iv >= m_per - tl && iv <= m_per + tl) begin
                  m_miss = 0;
                  if (iv > m_per && m_per < ONES - 1) m_per++;
                  else if (iv < m_per && m_per > 4) m_per--;
                  if (m_st == 3) begin
                     ps = 1;
                  end else begin
                     m_hits++;
                     if (m_hits == 16) begin
                        m_st = 3; m_lk = 1; ps = 1;
                     end
                  end
               end else if (iv < 2 * per0 - tl) begin
                  m_miss++;
                  if (m_miss == 4) lose = 1;
               end
            end
         end
      end
`ifdef BIT_LOCK_TIMEOUT_EN
      else if (trk0 && m_tc > per0 * 32) begin
         lose = 1;
      end
      if (rs || !trk0 || es) m_tc = 0;
      else if (m_tc < (64'd1 << 37) - 1) m_tc++;
`endif
      if (lose || drop) begin
         m_st = 0; m_per = ONES; m_pv = 0; m_lk = 0;
         m_stab = 0; m_hits = 0; m_miss = 0; ps = 0;
         if (lose && m_lc < 255) m_lc++;
      end
      s.st = 2'(m_st);
      s.per = m_per[31:0];
      s.pv = m_pv;
      s.lk = m_lk;
      s.ps = ps;
      s.lc = 8'(m_lc);
      exp_q.push_back(s);
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, expv);
      end
   endtask

   task automatic cycle(input logic es,
                        input logic [31:0] iv,
                        input logic rs);
      snap_t o;
      snap_t e;
      edge_strobe = es;
      interval = iv;
      restart = rs;
      model_step(es, iv, rs);
      @(posedge clk_300M);
      #1;
      edge_strobe = 1'b0;
      interval = '0;
      restart = 1'b0;
      o = {state, period, period_valid, locked,
           phase_sync, loss_cnt};
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard: queue empty");
      end else begin
         e = exp_q.pop_front();
         assert (o === e) else begin
            n_err++;
            $error("FAIL cycle: observed st=%0d per=%0h pv=%0b lk=%0b ps=%0b lc=%0d expected st=%0d per=%0h pv=%0b lk=%0b ps=%0b lc=%0d",
                   o.st, o.per, o.pv, o.lk, o.ps, o.lc,
                   e.st, e.per, e.pv, e.lk, e.ps, e.lc);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 1'b0);
   endtask

   task automatic edge_in(input logic [31:0] iv);
      cycle(1'b1, iv, 1'b0);
   endtask

   task automatic lock40();
      for (int k = 0; k < 34; k++) begin
         edge_in(32'd40);
         idle(3);
      end
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_period", period, 32'hFFFF_FFFF);
      chk("rst_pv", 32'(period_valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_loss", 32'(loss_cnt), 32'd0);
      chk("rst_ps", 32'(phase_sync), 32'd0);
      @(negedge clk_300M);
      rst_n = 1'b1;
      idle(2);

      edge_in(32'd3);
      chk("glitch_idle", 32'(state), 32'd0);
      idle(2);

      for (int i = 1; i <= 34; i++) begin
         edge_in(32'd40);
         if (i == 1) chk("e1_acq", 32'(state), 32'd1);
         if (i == 2) chk("e2_per", period, 32'd40);
         if (i == 17) chk("e17_acq", 32'(state), 32'd1);
         if (i == 18) begin
            chk("e18_trk", 32'(state), 32'd2);
            chk("e18_pv", 32'(period_valid), 32'd1);
         end
         if (i == 33) chk("e33_unlk", 32'(locked), 32'd0);
         if (i == 34) begin
            chk("e34_lk", 32'(locked), 32'd1);
            chk("e34_ps", 32'(phase_sync), 32'd1);
            chk("e34_st", 32'(state), 32'd3);
         end
         idle(3);
      end

      edge_in(32'd42);
      chk("trk42_a", period, 32'd41);
      idle(3);
      edge_in(32'd42);
      chk("trk42_b", period, 32'd42);
      chk("trk42_lk", 32'(locked), 32'd1);
      idle(3);
      edge_in(32'd40);
      idle(3);
      edge_in(32'd40);
      chk("back40", period, 32'd40);
      idle(3);

      edge_in(32'd50);
      idle(3);
      edge_in(32'd50);
      idle(3);
      edge_in(32'd80);
      chk("ign80_per", period, 32'd40);
      chk("ign80_ps", 32'(phase_sync), 32'd0);
      idle(3);
      edge_in(32'd120);
      chk("ign120_per", period, 32'd40);
      idle(3);
      edge_in(32'd3);
      chk("glitch_lk", 32'(state), 32'd3);
      idle(3);
      edge_in(32'd50);
      chk("miss3_lk", 32'(locked), 32'd1);
      idle(3);
      edge_in(32'd40);
      chk("hit_ps", 32'(phase_sync), 32'd1);
      idle(3);

      for (int i = 1; i <= 4; i++) begin
         edge_in(32'd50);
         if (i == 3) chk("miss_hold", 32'(state), 32'd3);
         idle(3);
      end
      chk("loss_st", 32'(state), 32'd0);
      chk("loss_lk", 32'(locked), 32'd0);
      chk("loss_per", period, 32'hFFFF_FFFF);
      chk("loss_cnt1", 32'(loss_cnt), 32'd1);

      lock40();
      chk("relock", 32'(locked), 32'd1);
      cycle(1'b1, 32'd40, 1'b1);
      chk("rs_st", 32'(state), 32'd0);
      chk("rs_loss", 32'(loss_cnt), 32'd1);
      chk("rs_ps", 32'(phase_sync), 32'd0);
      idle(3);

      lock40();
      idle(1400);
`ifdef BIT_LOCK_TIMEOUT_EN
      chk("tmo_st", 32'(state), 32'd0);
      chk("tmo_loss", 32'(loss_cnt), 32'd2);
`else
      chk("notmo_st", 32'(state), 32'd3);
      chk("notmo_lk", 32'(locked), 32'd1);
`endif

      edge_in(32'd40);
      idle(2);
      edge_in(32'd40);
      idle(2);
      edge_in(32'd40);
      idle(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_st", 32'(state), 32'd0);
      chk("arst_per", period, 32'hFFFF_FFFF);
      chk("arst_pv", 32'(period_valid), 32'd0);
      chk("arst_loss", 32'(loss_cnt), 32'd0);
      model_reset();
      #3;
      rst_n = 1'b1;
      edge_in(32'd40);
      chk("post_rst", 32'(state), 32'd1);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bit_lock_ctrl.md
# bit_lock_ctrl

Acquisition and lock controller for the bit-clock recovery datapath. Consumes the per-edge interval measurement from the edge/interval counter, sequences acquisition → tracking → lock, and drives the period word and phase-realign strobe that configure the recovered-clock generator. Runs in the 300 MHz sampling domain and exposes lock status and a loss counter for LEDs/debug.

## Interface
- CLK_LEN, 32: width of interval and period words
- STABLE_LEN, 4: acquisition stability counter width; 2^STABLE_LEN non-updating edges end acquisition
- LOCK_EDGES, 16: consecutive-or-not hits in TRACK required to declare lock
- MISS_LIMIT, 4: consecutive misses in TRACK/LOCKED that force loss
- TOL_SHIFT, 3: hit tolerance tol = period >> TOL_SHIFT
- MIN_PERIOD, 4: intervals below this are glitches, always ignored; period floor
- TIMEOUT_SHIFT, 5: edge timeout = period << TIMEOUT_SHIFT cycles (macro-gated)
- clk_300M  in  1  sampling clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- edge_strobe  in  1  one-cycle pulse per falling edge of sampled signal
- interval  in  CLK_LEN  cycles since previous edge, valid with edge_strobe, saturating
- restart  in  1  one-cycle pulse (debounced key) forcing re-acquisition
- period  out  CLK_LEN  current bit-period estimate to clock generator
- period_valid  out  1  period usable by clock generator
- phase_sync  out  1  one-cycle realign request to clock generator
- locked  out  1  lock indicator
- state  out  2  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3
- loss_cnt  out  8  lock-loss events, saturates at 255

## Operation
- Reset: state IDLE, period all-ones, period_valid 0, phase_sync 0, locked 0, loss_cnt 0, internal counters 0.
- Edges with interval < MIN_PERIOD ignored in every state.
- IDLE: first edge → ACQUIRE; its interval discarded.
- ACQUIRE: per edge, interval < period → period ← interval, stable ← 0; else stable ← stable+1. Non-updating edge with stable all-ones → TRACK, period_valid ← 1, hit/miss counters ← 0.
- Classification (TRACK, LOCKED), tol from current period, compares in CLK_LEN+1 bits: hit if period−tol ≤ interval ≤ period+tol; ignored (multi-bit run) if interval ≥ 2·period−tol; otherwise miss (incl. short intervals).
- Hit: miss counter ← 0; period ± 1 toward interval (unchanged if equal), never below MIN_PERIOD nor above all-ones−1.
- TRACK: LOCK_EDGES-th hit → LOCKED, locked ← 1.
- LOCKED: every hit pulses phase_sync (including the locking hit).
- MISS_LIMIT-th consecutive miss in TRACK or LOCKED: loss → IDLE, period all-ones, period_valid 0, locked 0, loss_cnt+1 (saturating).
- restart: any state → IDLE as loss but loss_cnt unchanged; wins over coincident edge_strobe.

## Timing
- All outputs registered; state/period/locked/phase_sync update in the cycle after edge_strobe (latency 1).
- phase_sync high exactly one cycle per qualifying hit.
- Back-to-back edge_strobe each processed; no input stall.
- rst_n assertion mid-operation returns all outputs to reset values immediately.

## Configuration
- BIT_LOCK_TIMEOUT_EN defined: in TRACK/LOCKED a cycles-since-edge counter (width CLK_LEN+TIMEOUT_SHIFT, saturating, cleared by edge_strobe) exceeding period << TIMEOUT_SHIFT causes loss exactly as MISS_LIMIT does.
- Undefined: no timeout logic; loss only via misses or restart.

## Test plan
- Reset → state 0, period 0xFFFFFFFF, period_valid 0, locked 0, loss_cnt 0.
- Edges every 40 cycles: edge 1 → ACQUIRE, edge 2 → period 40, edge 18 → TRACK with period_valid 1, edge 34 → locked 1 with phase_sync pulse.
- Locked at 40, intervals 42: period steps 41, 42 on successive hits; locked stays 1.
- Locked at 40, intervals 80 and 120: ignored, period 40, no phase_sync, miss count unchanged.
- Locked at 40, four intervals of 50 → IDLE, locked 0, period 0xFFFFFFFF, loss_cnt 1; restart coincident with an edge → IDLE, loss_cnt unchanged.
- With BIT_LOCK_TIMEOUT_EN, locked at 40, edges stop → loss after 1280 cycles; without it, stays LOCKED.
